// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/clear FSM, tick prescaler and a four-digit BCD count
// (ss.cc, 00.00 .. 59.99).
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   i_rst_n  asynchronous active-low reset
//   i_start  start/stop press, one event per high cycle
//   i_clr    clear press, one event per high cycle
//   o_run    high while running
//   o_bcd    {d3,d2,d1,d0}: tens of s, s, 1/10 s, 1/100 s
//   o_wrap   one-cycle pulse when the count rolls over from 59.99 to 00.00
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_clr,
  output logic        o_run,
  output logic [15:0] o_bcd,
  output logic        o_wrap
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e          state_q;
  logic [PreW-1:0] pre_q;
  logic [3:0]      d0_q, d1_q, d2_q, d3_q;
  logic            run_q;
  logic            wrap_q;

  logic            tick;
  logic            at_max;
  logic [3:0]      d0_inc, d1_inc, d2_inc, d3_inc;

  assign tick   = (state_q == StRun) && (pre_q == PreMax);
  assign at_max = (d3_q == 4'd5) && (d2_q == 4'd9) && (d1_q == 4'd9) && (d0_q == 4'd9);

  // Count value one tick ahead, with ripple carry through the digits.
  always_comb begin
    d0_inc = d0_q;
    d1_inc = d1_q;
    d2_inc = d2_q;
    d3_inc = d3_q;
    if (d0_q == 4'd9) begin
      d0_inc = 4'd0;
      if (d1_q == 4'd9) begin
        d1_inc = 4'd0;
        if (d2_q == 4'd9) begin
          d2_inc = 4'd0;
          d3_inc = (d3_q == 4'd5) ? 4'd0 : d3_q + 4'd1;
        end else begin
          d2_inc = d2_q + 4'd1;
        end
      end else begin
        d1_inc = d1_q + 4'd1;
      end
    end else begin
      d0_inc = d0_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      pre_q   <= '0;
      d0_q    <= 4'd0;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      d3_q    <= 4'd0;
      run_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Clear beats start here; clearing an already-zero count is harmless.
          if (i_clr) begin
            pre_q <= '0;
            d0_q  <= 4'd0;
            d1_q  <= 4'd0;
            d2_q  <= 4'd0;
            d3_q  <= 4'd0;
          end else if (i_start) begin
            state_q <= StRun;
            run_q   <= 1'b1;
          end
        end
        StRun: begin
          pre_q <= tick ? '0 : pre_q + 1'b1;
          // A tick coinciding with a stop press is still counted.
          if (tick) begin
            d0_q   <= d0_inc;
            d1_q   <= d1_inc;
            d2_q   <= d2_inc;
            d3_q   <= d3_inc;
            wrap_q <= at_max;
          end
          // Clear is ignored while running; start wins when both are pressed.
          if (i_start) begin
            state_q <= StPause;
            run_q   <= 1'b0;
          end
        end
        StPause: begin
          // Prescaler holds here so a resume keeps the partial tick.
          if (i_clr) begin
            state_q <= StIdle;
            pre_q   <= '0;
            d0_q    <= 4'd0;
            d1_q    <= 4'd0;
            d2_q    <= 4'd0;
            d3_q    <= 4'd0;
          end else if (i_start) begin
            state_q <= StRun;
            run_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          pre_q   <= '0;
          d0_q    <= 4'd0;
          d1_q    <= 4'd0;
          d2_q    <= 4'd0;
          d3_q    <= 4'd0;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_run  = run_q;
  assign o_bcd  = {d3_q, d2_q, d1_q, d0_q};
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam int unsigned Div = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clr;
  logic        run;
  logic [15:0] bcd;
  logic        wrap;

  stopwatch_ctrl #(
    .TICK_DIV(Div)
  ) dut (
    .clk    (clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_clr  (clr),
    .o_run  (run),
    .o_bcd  (bcd),
    .o_wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        run;
    logic [15:0] bcd;
    logic        wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: mode 0 = stopped at zero, 1 = running, 2 = paused.
  // Elapsed time is kept as plain centiseconds; phase counts clocks within the current 10 ms.
  int m_mode  = 0;
  int m_cs    = 0;
  int m_phase = 0;
  bit m_wrap  = 0;

  function automatic logic [15:0] to_bcd(input int cs);
    logic [3:0] a, b, c, d;
    a = 4'(cs / 1000);
    b = 4'((cs / 100) % 10);
    c = 4'((cs / 10) % 10);
    d = 4'(cs % 10);
    return {a, b, c, d};
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_cs    = 0;
    m_phase = 0;
    m_wrap  = 0;
  endtask

  task automatic model_step(input bit s, input bit c);
    int mode_next;
    m_wrap    = 0;
    mode_next = m_mode;
    if (m_mode == 1) begin
      if (m_phase == Div - 1) begin
        m_phase = 0;
        m_cs    = m_cs + 1;
        if (m_cs == 6000) begin
          m_cs   = 0;
          m_wrap = 1;
        end
      end else begin
        m_phase = m_phase + 1;
      end
      if (s) mode_next = 2;
    end else begin
      if (c) begin
        mode_next = 0;
        m_cs      = 0;
        m_phase   = 0;
      end else if (s) begin
        mode_next = 1;
      end
    end
    m_mode = mode_next;
  endtask

  // One clock of stimulus: drive on the falling edge and queue the response due after the
  // following rising edge.
  task automatic step(input bit s, input bit c);
    exp_t e;
    @(negedge clk);
    start = s;
    clr   = c;
    model_step(s, c);
    e.run  = (m_mode == 1);
    e.bcd  = to_bcd(m_cs);
    e.wrap = m_wrap;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (run !== 1'b0 || bcd !== 16'h0000 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got run=%0b bcd=%h wrap=%0b, want run=0 bcd=0000 wrap=0",
               name, run, bcd, wrap);
    end
  endtask

  // Monitor: compares every queued expectation #1 after the edge it refers to.
  logic prev_wrap = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (run !== e.run || bcd !== e.bcd || wrap !== e.wrap) begin
        n_fail++;
        $display("FAIL out_cmp t=%0t: got run=%0b bcd=%h wrap=%0b, want run=%0b bcd=%h wrap=%0b",
                 $time, run, bcd, wrap, e.run, e.bcd, e.wrap);
      end
      n_checks++;
      if (bcd[3:0] > 4'd9 || bcd[7:4] > 4'd9 || bcd[11:8] > 4'd9 || bcd[15:12] > 4'd5) begin
        n_fail++;
        $display("FAIL bcd_legal t=%0t: got bcd=%h, want digits <=9 and d3 <=5", $time, bcd);
      end
      n_checks++;
      if (prev_wrap === 1'b1 && wrap === 1'b1) begin
        n_fail++;
        $display("FAIL wrap_pulse t=%0t: got wrap high two cycles, want single cycle", $time);
      end
    end
    prev_wrap = wrap;
  end

  initial begin
    start = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1 check_zero("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // First start, first tick after 4 clocks, 0x0010 after 40.
    step(1'b1, 1'b0);
    idle(45);

    // Pause two prescaler counts into a tick, resume, partial tick is kept.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    while (m_phase != 2) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle(20);
    step(1'b1, 1'b0);
    idle(10);

    // Stop press on the same cycle as a tick: tick counted, then paused.
    while (m_phase != Div - 1) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle(6);
    step(1'b1, 1'b0);
    idle(9);

    // Clear ignored in RUN; clear in PAUSE; simultaneous presses.
    step(1'b0, 1'b1);
    idle(3);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b0);
    idle(13);
    step(1'b1, 1'b1);
    idle(5);
    step(1'b1, 1'b1);
    idle(3);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    idle(7);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    idle(3);

    // Randomised presses.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
    end

    // Full run through 59.99 -> 00.00 with stray clear presses that must be ignored.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 6000 * Div + 40; i++) begin
      step(1'b0, $urandom_range(0, 99) == 0);
    end

    // Asynchronous reset mid-run at 01.23.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    while (m_cs != 123) step(1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge clk);
    start = 1'b1;
    clr   = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_zero("inputs_in_reset");
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
    #1 rst_n = 1'b1;
    idle(10);
    step(1'b1, 1'b0);
    idle(8);

    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
